shift_add_mul: RTL

SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

---
 rtl/mul_pkg.sv | 17 +
 rtl/shift_add_mul_add_rca.sv | 24 ++
 rtl/shift_add_mul.sv | 111 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count RUN cycles 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/shift_add_mul_add_rca.sv
// Parameterised N-bit ripple-carry adder for the multiplier accumulate.
// Latency: combinational; carry ripples bit 0 to bit N-1.
// Backpressure: none; carry-out is dropped because operands never overflow.
module add_rca #(
    parameter int N = 12
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] s_o
);

    logic [N-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_sum
        assign s_o[i] = a_i[i] ^ b_i[i] ^ carry[i];
    end

    for (genvar i = 0; i < N - 1; i++) begin : g_carry
        assign carry[i+1] = (a_i[i] & b_i[i]) | (a_i[i] & carry[i]) | (b_i[i] & carry[i]);
    end

endmodule

// File: rtl/shift_add_mul.sv
// Unsigned W x W sequential shift-and-add multiplier (optional addend via SHIFT_ADD_MUL_ADDEND_EN).
// Latency: W RUN cycles; OUT_VALID is seen on the (W+1)th edge counting the transfer edge.
// Backpressure: result held in DONE until OUT_READY; new operands accepted only in IDLE.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int W = 6
) (
    input  logic           CLK,
    input  logic           RSTN,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
`ifdef SHIFT_ADD_MUL_ADDEND_EN
    input  logic [W-1:0]   R,
`endif
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [2*W-1:0] P,
    output logic           BUSY
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t          state_q, state_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [2*W-1:0]  addend;
    logic [2*W-1:0]  sum;
    logic [2*W-1:0]  acc_init;

`ifdef SHIFT_ADD_MUL_ADDEND_EN
    assign acc_init = {{W{1'b0}}, R};
`else
    assign acc_init = '0;
`endif

    // Partial product for this step: the shifted multiplicand when the current multiplier bit is set.
    assign addend = mplier_q[0] ? mcand_q : '0;

    add_rca #(.N(2 * W)) u_add (
        .a_i (acc_q),
        .b_i (addend),
        .s_o (sum)
    );

    // Handshake outputs come from the state register alone, so no input-to-output combinational path.
    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign BUSY      = (state_q != IDLE);
    assign P         = (state_q == DONE) ? acc_q : '0;

    // Next-state and datapath update: capture in IDLE, fixed W shift/add steps in RUN, hold in DONE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    mcand_d  = {{W{1'b0}}, A};
                    mplier_d = B;
                    acc_d    = acc_init;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // No early exit on a zero multiplier: latency is operand-independent.
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
